// File: rtl/taxi_eth_stat_accum.sv
// Statistics accumulator: per-ID counters in block RAM, updated from the MAC
// stat stream by a two-stage read-modify-write, with a host read/clear port.
module taxi_eth_stat_accum #(
    parameter int STAT_INC_W = 16,
    parameter int STAT_ID_W  = 8,
    parameter int CNT        = 256,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STAT_INC_W-1:0] s_axis_stat_tdata,
    input  logic [STAT_ID_W-1:0]  s_axis_stat_tid,
    input  logic                  s_axis_stat_tuser,
    input  logic                  s_axis_stat_tvalid,
    output logic                  s_axis_stat_tready,
    input  logic                  rd_en,
    input  logic [STAT_ID_W-1:0]  rd_addr,
    input  logic                  rd_clr,
    output logic [CNT_W-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  init_done
);

    localparam logic [STAT_ID_W:0] CNT_L     = (STAT_ID_W+1)'(CNT);
    localparam logic [STAT_ID_W:0] INIT_LAST = (STAT_ID_W+1)'(CNT - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                 state_q, state_d;
    logic [STAT_ID_W:0]     init_cnt_q, init_cnt_d;
    logic                   init_done_q, init_done_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]       rd_data_q, rd_data_d;

    // stage-1 operation (host read or stat beat) and forwarded RAM data
    logic                   s1_vld_q, s1_vld_d;
    logic                   s1_rd_q, s1_rd_d;
    logic                   s1_clr_q, s1_clr_d;
    logic                   s1_ld_q, s1_ld_d;
    logic                   s1_inr_q, s1_inr_d;
    logic [STAT_ID_W-1:0]   s1_addr_q, s1_addr_d;
    logic [STAT_INC_W-1:0]  s1_inc_q, s1_inc_d;
    logic                   fwd_q, fwd_d;
    logic [CNT_W-1:0]       fwd_data_q, fwd_data_d;

    logic [CNT_W-1:0]       mem [CNT];
    logic [CNT_W-1:0]       mem_rdata_q;
    logic                   mem_we;
    logic [STAT_ID_W-1:0]   mem_wa;
    logic [CNT_W-1:0]       mem_wd;
    logic [STAT_ID_W-1:0]   mem_ra;

    logic [CNT_W-1:0]       rdval;
    logic [CNT_W-1:0]       inc_ext;
    logic [CNT_W-1:0]       sum;
    logic [STAT_ID_W-1:0]   op_addr;
    logic                   op_inr;

    // Next-state logic: RAM init sweep, stage-0 issue, stage-1 write-back
    always_comb begin
        state_d            = state_q;
        init_cnt_d         = init_cnt_q;
        init_done_d        = init_done_q;
        rd_valid_d         = 1'b0;
        rd_data_d          = rd_data_q;
        s1_vld_d           = 1'b0;
        s1_rd_d            = 1'b0;
        s1_clr_d           = 1'b0;
        s1_ld_d            = 1'b0;
        s1_inr_d           = 1'b0;
        s1_addr_d          = '0;
        s1_inc_d           = '0;
        fwd_d              = 1'b0;
        fwd_data_d         = '0;
        mem_we             = 1'b0;
        mem_wa             = '0;
        mem_wd             = '0;
        mem_ra             = '0;
        s_axis_stat_tready = 1'b0;

        // stage-1 operand: forwarded sum wins over the stale RAM output
        rdval   = fwd_q ? fwd_data_q : mem_rdata_q;
        inc_ext = CNT_W'(s1_inc_q);
        sum     = s1_ld_q ? inc_ext : rdval + inc_ext;

        // host read has priority for the shared read port
        op_addr = rd_en ? rd_addr : s_axis_stat_tid;
        op_inr  = {1'b0, op_addr} < CNT_L;

        case (state_q)
            ST_INIT: begin
                mem_we     = !rst;
                mem_wa     = init_cnt_q[STAT_ID_W-1:0];
                init_cnt_d = init_cnt_q + (STAT_ID_W+1)'(1);
                if (init_cnt_q == INIT_LAST) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (s1_vld_q) begin
                    if (s1_rd_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = s1_inr_q ? rdval : '0;
                        if (s1_clr_q && s1_inr_q) begin
                            mem_we = !rst;
                            mem_wa = s1_addr_q;
                        end
                    end else if (s1_inr_q) begin
                        mem_we = !rst;
                        mem_wa = s1_addr_q;
                        mem_wd = sum;
                    end
                end

                s_axis_stat_tready = !rd_en && !rst;

                if (rd_en || s_axis_stat_tvalid) begin
                    s1_vld_d   = 1'b1;
                    s1_rd_d    = rd_en;
                    s1_clr_d   = rd_en && rd_clr;
                    s1_ld_d    = !rd_en && s_axis_stat_tuser;
                    s1_inr_d   = op_inr;
                    s1_addr_d  = op_addr;
                    s1_inc_d   = s_axis_stat_tdata;
                    mem_ra     = op_inr ? op_addr : '0;
                    // same-address write this cycle lands after the RAM read
                    fwd_d      = mem_we && (mem_wa == op_addr);
                    fwd_data_d = mem_wd;
                end
            end
        endcase
    end

    // Control and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            s1_vld_q    <= 1'b0;
            s1_rd_q     <= 1'b0;
            s1_clr_q    <= 1'b0;
            s1_ld_q     <= 1'b0;
            s1_inr_q    <= 1'b0;
            s1_addr_q   <= '0;
            s1_inc_q    <= '0;
            fwd_q       <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            s1_vld_q    <= s1_vld_d;
            s1_rd_q     <= s1_rd_d;
            s1_clr_q    <= s1_clr_d;
            s1_ld_q     <= s1_ld_d;
            s1_inr_q    <= s1_inr_d;
            s1_addr_q   <= s1_addr_d;
            s1_inc_q    <= s1_inc_d;
            fwd_q       <= fwd_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    // Counter RAM: one write port, one synchronous read port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
        mem_rdata_q <= mem[mem_ra];
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_taxi_eth_stat_accum.sv
// Bench for taxi_eth_stat_accum: table vectors, hand sequences for wrap,
// contention and mid-stream reset, and a randomized run against a counter model.
module tb_taxi_eth_stat_accum;

    localparam int INC_W = 16;
    localparam int ID_W  = 8;
    localparam int NCNT  = 16;
    localparam int CW    = 24;

    logic              clk = 1'b0;
    logic              d_rst = 1'b1;
    logic [INC_W-1:0]  d_tdata = '0;
    logic [ID_W-1:0]   d_tid = '0;
    logic              d_tuser = 1'b0;
    logic              d_tvalid = 1'b0;
    logic              tready;
    logic              d_rd_en = 1'b0;
    logic [ID_W-1:0]   d_rd_addr = '0;
    logic              d_rd_clr = 1'b0;
    logic [CW-1:0]     rd_data;
    logic              rd_valid;
    logic              init_done;

    always #5 clk = ~clk;

    taxi_eth_stat_accum #(
        .STAT_INC_W (INC_W),
        .STAT_ID_W  (ID_W),
        .CNT        (NCNT),
        .CNT_W      (CW)
    ) dut (
        .clk                (clk),
        .rst                (d_rst),
        .s_axis_stat_tdata  (d_tdata),
        .s_axis_stat_tid    (d_tid),
        .s_axis_stat_tuser  (d_tuser),
        .s_axis_stat_tvalid (d_tvalid),
        .s_axis_stat_tready (tready),
        .rd_en              (d_rd_en),
        .rd_addr            (d_rd_addr),
        .rd_clr             (d_rd_clr),
        .rd_data            (rd_data),
        .rd_valid           (rd_valid),
        .init_done          (init_done)
    );

    // stimulus for the next cycle, applied by step()
    logic              rst = 1'b1;
    logic              tv = 1'b0, tu = 1'b0, re = 1'b0, rc = 1'b0;
    logic [ID_W-1:0]   tid = '0, ra = '0;
    logic [INC_W-1:0]  tdat = '0;
    logic              ovr_en = 1'b0;
    logic [CW-1:0]     ovr_val = '0;

    // reference model and outstanding reads
    logic [CW-1:0]     model [256];
    typedef struct { int unsigned cyc; logic [CW-1:0] exp; logic [ID_W-1:0] addr; } rd_t;
    rd_t               expq[$];

    int unsigned       cyc = 0, done_cyc = 0, c0 = 0;
    logic              seen_done = 1'b0;
    logic              last_acc = 1'b0;
    logic              tready_s = 1'b0;
    int unsigned       n_cmp = 0, n_err = 0;

    typedef struct {
        logic v; logic [ID_W-1:0] id; logic [INC_W-1:0] inc; logic ld;
        logic re; logic [ID_W-1:0] ra; logic rc; logic [CW-1:0] exp; logic tr;
    } vec_t;
    vec_t tab [18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        rd_t e;
        @(negedge clk);
        cyc++;
        if (init_done && !seen_done) begin
            seen_done = 1'b1;
            done_cyc  = cyc;
        end
        if (rd_valid) begin
            if (expq.size() == 0) begin
                chk("spurious_rd_valid", 64'(rd_valid), 64'd0);
            end else begin
                e = expq.pop_front();
                chk("rd_latency", 64'(cyc - e.cyc), 64'd2);
                chk($sformatf("rd_data[%0d]", e.addr), 64'(rd_data), 64'(e.exp));
            end
        end
        while (expq.size() > 0 && expq[0].cyc + 2 <= cyc) begin
            e = expq.pop_front();
            chk($sformatf("rd_valid_missing[%0d]", e.addr), 64'(rd_valid), 64'd1);
        end
        d_rst = rst; d_tvalid = tv; d_tid = tid; d_tdata = tdat; d_tuser = tu;
        d_rd_en = re; d_rd_addr = ra; d_rd_clr = rc;
        #1;
        tready_s = tready;
        last_acc = 1'b0;
        if (rst) begin
            expq.delete();
            for (int i = 0; i < 256; i++) model[i] = '0;
        end else begin
            if (tv && tready) begin
                last_acc = 1'b1;
                if (tid < NCNT) model[tid] = tu ? CW'(tdat) : model[tid] + CW'(tdat);
            end
            if (re && init_done) begin
                e.cyc = cyc; e.addr = ra;
                e.exp = ovr_en ? ovr_val : ((ra < NCNT) ? model[ra] : '0);
                expq.push_back(e);
                if (rc && ra < NCNT) model[ra] = '0;
            end
        end
    endtask

    task automatic idle(input int n);
        tv = 1'b0; re = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic beat(input logic [ID_W-1:0] id, input logic [INC_W-1:0] inc, input logic ld);
        logic ok;
        ok = 1'b0;
        tv = 1'b1; tid = id; tdat = inc; tu = ld; re = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            ok = last_acc;
        end
        if (!ok) chk("beat_accept_timeout", 64'd0, 64'd1);
        tv = 1'b0; tu = 1'b0;
    endtask

    task automatic rd(input logic [ID_W-1:0] a, input logic clr, input logic oe, input logic [CW-1:0] ov);
        tv = 1'b0; re = 1'b1; ra = a; rc = clr; ovr_en = oe; ovr_val = ov;
        step();
        re = 1'b0; rc = 1'b0; ovr_en = 1'b0;
    endtask

    // reset, wait for init while poking rd_en/tvalid, then check init timing
    task automatic do_init();
        rst = 1'b0; seen_done = 1'b0;
        tv = 1'b1; tid = 8'd1; tdat = 16'd1; re = 1'b1; ra = 8'd1;
        step();
        c0 = cyc;
        for (int i = 0; i < NCNT + 4; i++) begin
            tv = !init_done; re = !init_done;
            step();
            if (!init_done) chk("init_tready", 64'(tready_s), 64'd0);
        end
        tv = 1'b0; re = 1'b0;
        chk("init_done_seen", 64'(seen_done), 64'd1);
        chk("init_cycles", 64'(done_cyc - c0), 64'(NCNT));
    endtask

    initial begin
        int unsigned nacc, guard;
        for (int i = 0; i < 256; i++) model[i] = '0;

        tab[0]  = '{1'b1, 8'd5,  16'd3,      1'b0, 1'b0, 8'd0,  1'b0, 24'd0,      1'b1};
        tab[1]  = '{1'b1, 8'd5,  16'd7,      1'b0, 1'b0, 8'd0,  1'b0, 24'd0,      1'b1};
        tab[2]  = '{1'b0, 8'd0,  16'd0,      1'b0, 1'b1, 8'd5,  1'b0, 24'd10,     1'b0};
        tab[3]  = '{1'b1, 8'd2,  16'd6,      1'b0, 1'b0, 8'd0,  1'b0, 24'd0,      1'b1};
        tab[4]  = '{1'b0, 8'd0,  16'd0,      1'b0, 1'b0, 8'd0,  1'b0, 24'd0,      1'b1};
        tab[5]  = '{1'b1, 8'd2,  16'd4,      1'b0, 1'b1, 8'd2,  1'b1, 24'd6,      1'b0};
        tab[6]  = '{1'b1, 8'd2,  16'd4,      1'b0, 1'b0, 8'd0,  1'b0, 24'd0,      1'b1};
        tab[7]  = '{1'b0, 8'd0,  16'd0,      1'b0, 1'b1, 8'd2,  1'b0, 24'd4,      1'b0};
        tab[8]  = '{1'b1, 8'd20, 16'd9,      1'b0, 1'b0, 8'd0,  1'b0, 24'd0,      1'b1};
        tab[9]  = '{1'b0, 8'd0,  16'd0,      1'b0, 1'b1, 8'd20, 1'b0, 24'd0,      1'b0};
        tab[10] = '{1'b1, 8'd3,  16'd100,    1'b0, 1'b0, 8'd0,  1'b0, 24'd0,      1'b1};
        tab[11] = '{1'b1, 8'd3,  16'h1234,   1'b1, 1'b0, 8'd0,  1'b0, 24'd0,      1'b1};
        tab[12] = '{1'b1, 8'd3,  16'd1,      1'b0, 1'b0, 8'd0,  1'b0, 24'd0,      1'b1};
        tab[13] = '{1'b0, 8'd0,  16'd0,      1'b0, 1'b1, 8'd3,  1'b0, 24'h1235,   1'b0};
        tab[14] = '{1'b0, 8'd0,  16'd0,      1'b0, 1'b1, 8'd5,  1'b1, 24'd10,     1'b0};
        tab[15] = '{1'b0, 8'd0,  16'd0,      1'b0, 1'b1, 8'd5,  1'b0, 24'd0,      1'b0};
        tab[16] = '{1'b0, 8'd0,  16'd0,      1'b0, 1'b0, 8'd0,  1'b0, 24'd0,      1'b1};
        tab[17] = '{1'b0, 8'd0,  16'd0,      1'b0, 1'b0, 8'd0,  1'b0, 24'd0,      1'b1};

        // reset state
        rst = 1'b1;
        step(); step(); step();
        @(posedge clk); #1;
        chk("rst_tready", 64'(tready), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);

        do_init();
        idle(3);
        for (int i = 0; i < NCNT; i++) rd(ID_W'(i), 1'b0, 1'b1, '0);
        rd(8'd16, 1'b0, 1'b1, '0);
        rd(8'd255, 1'b0, 1'b1, '0);
        idle(3);

        // table-driven vectors, one record per cycle
        for (int i = 0; i < 18; i++) begin
            tv = tab[i].v; tid = tab[i].id; tdat = tab[i].inc; tu = tab[i].ld;
            re = tab[i].re; ra = tab[i].ra; rc = tab[i].rc;
            ovr_en = tab[i].re; ovr_val = tab[i].exp;
            step();
            chk($sformatf("tab_tready[%0d]", i), 64'(tready_s), 64'(tab[i].tr));
        end
        tv = 1'b0; re = 1'b0; rc = 1'b0; tu = 1'b0; ovr_en = 1'b0;

        // wrap: load chain to 2**24-2, then +5
        beat(8'd9, 16'hFFFE, 1'b1);
        for (int i = 0; i < 255; i++) beat(8'd9, 16'hFFFF, 1'b0);
        beat(8'd9, 16'h00FF, 1'b0);
        beat(8'd9, 16'd5, 1'b0);
        rd(8'd9, 1'b0, 1'b1, 24'd3);
        idle(3);

        // randomized beats with random host reads/clears
        nacc = 0; guard = 0;
        tid = ID_W'($urandom_range(0, 7)); tdat = INC_W'($urandom); tu = ($urandom_range(0, 15) == 0);
        while (nacc < 1000 && guard < 5000) begin
            tv = 1'b1;
            re = ($urandom_range(0, 4) == 0);
            ra = ID_W'($urandom_range(0, 7));
            rc = ($urandom_range(0, 7) == 0);
            step();
            guard++;
            if (last_acc) begin
                nacc++;
                tid = ID_W'($urandom_range(0, 7)); tdat = INC_W'($urandom); tu = ($urandom_range(0, 15) == 0);
            end
        end
        chk("random_beats_done", 64'(nacc), 64'd1000);
        tv = 1'b0; re = 1'b0; rc = 1'b0; tu = 1'b0;
        idle(3);
        for (int i = 0; i < 8; i++) rd(ID_W'(i), 1'b0, 1'b0, '0);
        idle(3);

        // reset mid-stream with a read in flight
        beat(8'd1, 16'd50, 1'b0);
        tv = 1'b1; tid = 8'd1; tdat = 16'd7; re = 1'b1; ra = 8'd1; rc = 1'b0;
        step();
        re = 1'b0; rst = 1'b1;
        step(); step();
        chk("rst_init_done_drop", 64'(init_done), 64'd0);
        do_init();
        idle(3);
        for (int i = 0; i < NCNT; i++) rd(ID_W'(i), 1'b0, 1'b1, '0);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
